// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-operand and response bundle for alu_cmd_sequencer.
// The master side is the sequencer; the slave side is the command source plus the ALU.
interface alu_cmd_sequencer_if #(parameter int DATA_W = 8);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_W-1:0]     cmd_a;
  logic [DATA_W-1:0]     cmd_b;
  logic [2:0]            cmd_op;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [2:0]            alu_op;
  logic                  alu_start;
  logic                  alu_done;
  logic [2*DATA_W-1:0]   alu_result;
  logic                  alu_reset_n;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*DATA_W-1:0]   rsp_result;
  logic [2:0]            rsp_op;
  logic                  rsp_timeout;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, alu_start, alu_reset_n,
           rsp_valid, rsp_result, rsp_op, rsp_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_start, alu_reset_n,
           rsp_valid, rsp_result, rsp_op, rsp_timeout, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queued command front end for a start/done ALU: FIFO, issue FSM with done-timeout,
// and one registered response per command.
module alu_cmd_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_cmd_sequencer_if.master  bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, PULSE, EXEC, GAP, RESP} state_t;

  state_t              state, state_nx;
  cmd_t                mem [DEPTH];
  cmd_t                head;
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                full, empty, push, pop;
  logic [15:0]         tmo_cnt, tmo_cnt_nx;

  logic [DATA_W-1:0]   a_nx, b_nx;
  logic [2:0]          op_nx, rop_nx;
  logic                start_nx, arst_nx, rvalid_nx, rtmo_nx;
  logic [2*DATA_W-1:0] rresult_nx;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty         = (wr_ptr == rd_ptr);
  assign push          = bus.cmd_valid && !full;
  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.cmd_ready = !full;
  assign bus.busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
  end

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    tmo_cnt_nx = tmo_cnt;
    a_nx       = bus.alu_a;
    b_nx       = bus.alu_b;
    op_nx      = bus.alu_op;
    start_nx   = bus.alu_start;
    arst_nx    = 1'b1;
    rvalid_nx  = 1'b0;
    rresult_nx = bus.rsp_result;
    rop_nx     = bus.rsp_op;
    rtmo_nx    = bus.rsp_timeout;
    case (state)
      IDLE: if (!empty) begin
        pop    = 1'b1;
        a_nx   = head.a;
        b_nx   = head.b;
        op_nx  = head.op;
        rop_nx = head.op;
        if (head.op == OP_NOP) begin
          start_nx = 1'b1;
          state_nx = PULSE;
        end else if (head.op == OP_RST) begin
          start_nx = 1'b0;
          arst_nx  = 1'b0;
          state_nx = PULSE;
        end else begin
          start_nx   = 1'b1;
          tmo_cnt_nx = '0;
          state_nx   = EXEC;
        end
      end
      PULSE: begin
        start_nx   = 1'b0;
        rresult_nx = '0;
        rtmo_nx    = 1'b0;
        state_nx   = RESP;
      end
      EXEC: begin
        tmo_cnt_nx = tmo_cnt + 16'd1;
        // done is checked first so a completion on the last allowed cycle still counts
        if (bus.alu_done) begin
          rresult_nx = bus.alu_result;
          start_nx   = 1'b0;
          rtmo_nx    = 1'b0;
          state_nx   = GAP;
        end else if (tmo_cnt == TO_LAST) begin
          rresult_nx = '0;
          start_nx   = 1'b0;
          rtmo_nx    = 1'b1;
          state_nx   = GAP;
        end
      end
      GAP: state_nx = RESP;
      RESP: begin
        if (bus.rsp_valid && bus.rsp_ready) state_nx = IDLE;
        else                                rvalid_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tmo_cnt         <= '0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_op      <= '0;
      bus.alu_start   <= 1'b0;
      bus.alu_reset_n <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_result  <= '0;
      bus.rsp_op      <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      state           <= state_nx;
      tmo_cnt         <= tmo_cnt_nx;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      bus.alu_a       <= a_nx;
      bus.alu_b       <= b_nx;
      bus.alu_op      <= op_nx;
      bus.alu_start   <= start_nx;
      bus.alu_reset_n <= arst_nx;
      bus.rsp_valid   <= rvalid_nx;
      bus.rsp_result  <= rresult_nx;
      bus.rsp_op      <= rop_nx;
      bus.rsp_timeout <= rtmo_nx;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: ALU model with operand-selected latency, response scoreboard,
// and literal latency/pulse-width expectations.
module tb_alu_cmd_sequencer;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] res;
    logic        tmo;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  alu_cmd_sequencer_if #(.DATA_W(DATA_W)) bus();

  alu_cmd_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour: operand a = 0xEn answers after n start cycles (n=0: never), otherwise after 3.
  function automatic int lat_of(input logic [7:0] a);
    return (a[7:4] == 4'hE) ? int'(a[3:0]) : 3;
  endfunction

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return {a, b};
    endcase
  endfunction

  function automatic rsp_t expect_of(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    int   l;
    l = lat_of(a);
    if (op == 3'd0 || op == 3'd7)       r = '{op: op, res: 16'h0, tmo: 1'b0};
    else if (l == 0 || l > TIMEOUT)     r = '{op: op, res: 16'h0, tmo: 1'b1};
    else                                r = '{op: op, res: alu_f(op, a, b), tmo: 1'b0};
    return r;
  endfunction

  int alu_cnt = 0;
  always @(posedge clk) alu_cnt <= bus.alu_start ? alu_cnt + 1 : 0;
  assign bus.alu_done   = bus.alu_start && (lat_of(bus.alu_a) != 0) && (alu_cnt == lat_of(bus.alu_a) - 1);
  assign bus.alu_result = bus.alu_done ? alu_f(bus.alu_op, bus.alu_a, bus.alu_b) : 16'hBAD0;

  // Pulse-width monitor for alu_start high and alu_reset_n low.
  int srun = 0, last_srun = 0, rrun = 0, last_rrun = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      srun = 0;
      rrun = 0;
    end else begin
      if (bus.alu_start) srun++;
      else if (srun != 0) begin last_srun = srun; srun = 0; end
      if (!bus.alu_reset_n) rrun++;
      else if (rrun != 0) begin last_rrun = rrun; rrun = 0; end
    end
  end

  // Scoreboard compare and hold-stability check on every valid response cycle.
  logic hold_prev = 1'b0;
  rsp_t held;
  always @(negedge clk) begin
    if (!reset_n) hold_prev = 1'b0;
    else begin
      if (hold_prev) begin
        checks++;
        if (!(bus.rsp_valid && bus.rsp_op == held.op && bus.rsp_result == held.res && bus.rsp_timeout == held.tmo)) begin
          failures++;
          $display("FAIL rsp_hold actual v=%0d op=%0d res=%h tmo=%0d required v=1 op=%0d res=%h tmo=%0d",
                   bus.rsp_valid, bus.rsp_op, bus.rsp_result, bus.rsp_timeout, held.op, held.res, held.tmo);
        end
      end
      if (bus.rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected actual op=%0d res=%h required no response", bus.rsp_op, bus.rsp_result);
        end else begin
          if (bus.rsp_op !== exp_q[0].op || bus.rsp_result !== exp_q[0].res || bus.rsp_timeout !== exp_q[0].tmo) begin
            failures++;
            $display("FAIL rsp_cmp actual op=%0d res=%h tmo=%0d required op=%0d res=%h tmo=%0d",
                     bus.rsp_op, bus.rsp_result, bus.rsp_timeout, exp_q[0].op, exp_q[0].res, exp_q[0].tmo);
          end
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
      end
      hold_prev = bus.rsp_valid && !bus.rsp_ready;
      held      = '{op: bus.rsp_op, res: bus.rsp_result, tmo: bus.rsp_timeout};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int acc, output int waited);
    waited = 0;
    acc    = -1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    while (!bus.cmd_ready && waited < 200) begin tick(); waited++; end
    if (!bus.cmd_ready) begin
      checks++; failures++;
      $display("FAIL push_wait actual=not_ready required=ready_within_200");
      bus.cmd_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      @(posedge clk);
      exp_q.push_back(expect_of(op, a, b));
      #1 bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input string tag, output int rise);
    int n = 0;
    while (!bus.rsp_valid && n < 200) begin tick(); n++; end
    rise = cyc;
    if (!bus.rsp_valid) begin
      checks++; failures++;
      $display("FAIL %s_wait actual=no_rsp required=rsp_within_200", tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, w, rise, hs, n, cnt;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0; bus.rsp_ready = 1'b1;

    // Reset values
    repeat (3) tick();
    chk("rst_start",   bus.alu_start,   0);
    chk("rst_alurstn", bus.alu_reset_n, 0);
    chk("rst_ready",   bus.cmd_ready,   1);
    chk("rst_busy",    bus.busy,        0);
    chk("rst_rvalid",  bus.rsp_valid,   0);
    chk("rst_alu_op",  {bus.alu_a, bus.alu_b, 5'd0, bus.alu_op}, 0);
    reset_n = 1'b1;
    tick();
    chk("rel_alurstn", bus.alu_reset_n, 1);

    // add FF+01, 3-cycle ALU
    push(3'd1, 8'hFF, 8'h01, acc, w);
    wait_rsp("add", rise);
    chk("add_res",   bus.rsp_result, 32'h0100);
    chk("add_op",    bus.rsp_op, 1);
    chk("add_tmo",   bus.rsp_timeout, 0);
    chk("add_srun",  last_srun, 3);
    chk("add_lat",   rise - acc, 6);
    tick();

    // mul FF*FF held by rsp_ready low; queued add must wait for handshake
    bus.rsp_ready = 1'b0;
    push(3'd4, 8'hFF, 8'hFF, acc, w);
    wait_rsp("mul", rise);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) push(3'd1, 8'h01, 8'h02, acc, w);
      else        tick();
      chk("mul_hold_v",   bus.rsp_valid, 1);
      chk("mul_hold_res", bus.rsp_result, 32'hFE01);
      chk("mul_no_issue", bus.alu_start, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    hs = cyc;
    wait_rsp("after_hold", rise);
    chk("next_after_hs", rise - hs, 6);
    chk("next_res", bus.rsp_result, 32'h0003);
    tick();

    // FIFO overflow with a silent ALU
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(3'd1, 8'hE0, 8'(i), acc, w);
      chk("ovf_no_wait", w, 0);
    end
    bus.cmd_valid = 1'b1;
    chk("ovf_full", bus.cmd_ready, 0);
    push(3'd2, 8'hE0, 8'h55, acc, w);
    chk("ovf_wait", w, 5);
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 300) begin tick(); n++; end
    chk("ovf_drain", (exp_q.size() == 0 && !bus.busy), 1);

    // Timeout, then a normal command; then done coinciding with the last allowed cycle
    push(3'd1, 8'hE0, 8'h01, acc, w);
    push(3'd3, 8'h5A, 8'h0F, acc, w);
    wait_rsp("tmo", rise);
    chk("tmo_flag", bus.rsp_timeout, 1);
    chk("tmo_res",  bus.rsp_result, 0);
    chk("tmo_srun", last_srun, 4);
    tick();
    wait_rsp("xor", rise);
    chk("xor_res", bus.rsp_result, 32'h0055);
    chk("xor_tmo", bus.rsp_timeout, 0);
    tick();
    push(3'd1, 8'hE4, 8'h01, acc, w);
    wait_rsp("edge4", rise);
    chk("edge4_res",  bus.rsp_result, 32'h00E5);
    chk("edge4_tmo",  bus.rsp_timeout, 0);
    chk("edge4_srun", last_srun, 4);
    tick();

    // no_op then rst_op
    push(3'd0, 8'h12, 8'h34, acc, w);
    wait_rsp("nop", rise);
    chk("nop_lat",  rise - acc, 3);
    chk("nop_srun", last_srun, 1);
    chk("nop_res",  bus.rsp_result, 0);
    tick();
    push(3'd7, 8'h56, 8'h78, acc, w);
    wait_rsp("rstop", rise);
    chk("rstop_lat",  rise - acc, 3);
    chk("rstop_rrun", last_rrun, 1);
    chk("rstop_res",  bus.rsp_result, 0);
    chk("rstop_op",   bus.rsp_op, 7);
    tick();

    // Reset in EXEC with two commands queued
    push(3'd1, 8'hE0, 8'h11, acc, w);
    push(3'd2, 8'h0F, 8'h33, acc, w);
    push(3'd3, 8'h0F, 8'h44, acc, w);
    chk("pre_rst_exec", bus.alu_start, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_start",   bus.alu_start, 0);
    chk("mid_rst_busy",    bus.busy, 0);
    chk("mid_rst_ready",   bus.cmd_ready, 1);
    chk("mid_rst_alurstn", bus.alu_reset_n, 0);
    chk("mid_rst_rvalid",  bus.rsp_valid, 0);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid) cnt++;
    end
    chk("post_rst_no_rsp", cnt, 0);
    chk("post_rst_busy",   bus.busy, 0);
    chk("final_q_empty",   exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
